pipeline_hazard_controller: RTL

//  Sequences the 5-stage pipeline around the decoded instruction stream.
//  - Detects load-use hazards and inserts one bubble (NOP = addi x0,x0,0) into execute.
//  - Flushes fetch/decode after a taken branch/jump.
//  - Freezes the whole pipe while data memory has not acknowledged a request.
//  - Keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipeline_hazard_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, data-memory freezes
// with timeout, and saturating stall/flush event counters for performance debug.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iDecodeValid,
    input  logic                  iDecodeUsesRs1,
    input  logic                  iDecodeUsesRs2,
    input  logic [REG_ADDR_W-1:0] iDecodeRs1,
    input  logic [REG_ADDR_W-1:0] iDecodeRs2,
    input  logic                  iExLoad,
    input  logic [REG_ADDR_W-1:0] iExRd,
    input  logic                  iBranchTaken,
    input  logic                  iMemReq,
    input  logic                  iMemAck,
    output logic                  oStallFetch,
    output logic                  oStallDecode,
    output logic                  oStallExecute,
    output logic                  oStallMem,
    output logic                  oBubbleExecute,
    output logic                  oFlushFetch,
    output logic                  oFlushDecode,
    output logic                  oMemError,
    output logic [CNT_W-1:0]      oStallCount,
    output logic [CNT_W-1:0]      oFlushCount
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_evt_q, stall_evt_d;
    logic [CNT_W-1:0] flush_evt_q, flush_evt_d;

    logic             hazard;
    logic             stall_all;
    logic             stall_front;
    logic             bubble;
    logic             flush;
    logic             redirect;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hazard = iDecodeValid & iExLoad & (iExRd != '0) &
                    ((iDecodeUsesRs1 & (iDecodeRs1 == iExRd)) |
                     (iDecodeUsesRs2 & (iDecodeRs2 == iExRd)));

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_all   = 1'b0;
        stall_front = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (iMemReq & ~iMemAck) begin
                    stall_all  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    ret_d      = ST_RUN;
                    wait_cnt_d = '0;
                end else if (iBranchTaken) begin
                    flush    = 1'b1;
                    redirect = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FC_RELOAD;
                    end
                end else if (hazard) begin
                    stall_front = 1'b1;
                    bubble      = 1'b1;
                end
            end

            // Only bubbles are in flight here, so branches and load-use are ignored.
            ST_FLUSH: begin
                if (iMemReq & ~iMemAck) begin
                    stall_all  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    ret_d      = ST_FLUSH;
                    wait_cnt_d = '0;
                end else begin
                    flush = 1'b1;
                    if (flush_cnt_q == FC_ONE) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_ONE;
                    end
                end
            end

            // The ack or timeout cycle releases the pipe without any flush or bubble.
            ST_MEM_WAIT: begin
                if (iMemAck) begin
                    state_d    = ret_q;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_LAST) begin
                    mem_err_d  = 1'b1;
                    state_d    = ret_q;
                    wait_cnt_d = '0;
                end else begin
                    stall_all  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end

            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
                wait_cnt_d  = '0;
            end
        endcase

        stall_evt_d = (stall_all | stall_front) ? sat_inc(stall_evt_q) : stall_evt_q;
        flush_evt_d = redirect ? sat_inc(flush_evt_q) : flush_evt_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_evt_q <= '0;
            flush_evt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_evt_q <= stall_evt_d;
            flush_evt_q <= flush_evt_d;
        end
    end

    // Reset forces every output low in the same cycle, regardless of inputs.
    assign oStallFetch    = ~iRst & (stall_all | stall_front);
    assign oStallDecode   = ~iRst & (stall_all | stall_front);
    assign oStallExecute  = ~iRst & stall_all;
    assign oStallMem      = ~iRst & stall_all;
    assign oBubbleExecute = ~iRst & bubble;
    assign oFlushFetch    = ~iRst & flush;
    assign oFlushDecode   = ~iRst & flush;
    assign oMemError      = ~iRst & mem_err_q;
    assign oStallCount    = iRst ? '0 : stall_evt_q;
    assign oFlushCount    = iRst ? '0 : flush_evt_q;

endmodule
